// File: rtl/kim_pip_pkg.sv
// Shared constants and types for the pipelined MIPS core front end.
package kim_pip_pkg;

    // Sequential PC step; applied by the external PC adder on operand b.
    localparam logic [31:0] PC_INC = 32'd4;

    // Default PC loaded on reset.
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    // Instruction word used to clear pipeline/skid storage.
    localparam logic [31:0] NOP = 32'h0000_0000;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,  // request outstanding to imem, waiting for grant
        S_WAIT = 2'd1,  // granted, waiting for the response
        S_HOLD = 2'd2,  // response parked in skid buffer while ID stalls
        S_DROP = 2'd3   // granted response is stale, discard on arrival
    } fetch_state_t;

endpackage

// File: rtl/kim_ifid_reg.sv
// IF/ID pipeline register: load a fetched instruction, hold under stall,
// insert a bubble otherwise, and kill the valid bit on a redirect.
import kim_pip_pkg::*;

module kim_ifid_reg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic                  clear,
    input  logic                  hold,
    input  logic [DATA_WIDTH-1:0] instr_in,
    input  logic [DATA_WIDTH-1:0] pc_in,
    input  logic [DATA_WIDTH-1:0] pc4_in,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] pc4
);

    logic                  valid_r;
    logic [DATA_WIDTH-1:0] instr_r;
    logic [DATA_WIDTH-1:0] pc_r;
    logic [DATA_WIDTH-1:0] pc4_r;

    // Pipeline register update; clear (redirect) beats load and hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_r <= 1'b0;
            instr_r <= DATA_WIDTH'(NOP);
            pc_r    <= {DATA_WIDTH{1'b0}};
            pc4_r   <= {DATA_WIDTH{1'b0}};
        end else if (clear) begin
            // Wrong-path instruction must not reach ID; fields are don't-care.
            valid_r <= 1'b0;
        end else if (load) begin
            valid_r <= 1'b1;
            instr_r <= instr_in;
            pc_r    <= pc_in;
            pc4_r   <= pc4_in;
        end else if (hold) begin
            valid_r <= valid_r;
        end else begin
            // ID consumed the entry and nothing new arrived: bubble.
            valid_r <= 1'b0;
        end
    end

    assign valid = valid_r;
    assign instr = instr_r;
    assign pc    = pc_r;
    assign pc4   = pc4_r;

endmodule

// File: rtl/kim_if_pc_fetch.sv
// Instruction-fetch front end: PC register, single-outstanding imem request
// sequencer with stale-response discard, one-entry skid buffer and IF/ID load.
import kim_pip_pkg::*;

module kim_if_pc_fetch #(
    parameter int                         DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]      RESET_PC   = RESET_PC_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic [DATA_WIDTH-1:0] pc_o,
    input  logic [DATA_WIDTH-1:0] pc_seq_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    input  logic                  stall_i,
    output logic                  imem_req_o,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_gnt_i,
    input  logic                  imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    output logic                  ifid_valid_o,
    output logic [DATA_WIDTH-1:0] ifid_instr_o,
    output logic [DATA_WIDTH-1:0] ifid_pc_o,
    output logic [DATA_WIDTH-1:0] ifid_pc4_o
);

    fetch_state_t          state_r;
    logic [DATA_WIDTH-1:0] pc_r;
    logic [DATA_WIDTH-1:0] hold_buf_r;

    logic                  load_s;
    logic [DATA_WIDTH-1:0] load_data_s;

    // Decide whether IF/ID is written this cycle and from which source.
    always_comb begin
        load_s      = 1'b0;
        load_data_s = hold_buf_r;
        case (state_r)
            S_WAIT: begin
                if (imem_rvalid_i && !stall_i && !redirect_i) begin
                    load_s      = 1'b1;
                    load_data_s = imem_rdata_i;
                end else begin
                    load_s      = 1'b0;
                    load_data_s = hold_buf_r;
                end
            end
            S_HOLD: begin
                if (!stall_i && !redirect_i) begin
                    load_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            default: begin
                load_s      = 1'b0;
                load_data_s = hold_buf_r;
            end
        endcase
    end

    // Fetch sequencer, PC register and skid buffer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= S_REQ;
            pc_r       <= RESET_PC;
            hold_buf_r <= DATA_WIDTH'(NOP);
        end else begin
            // Redirect target always wins; otherwise advance only on a load.
            if (redirect_i) begin
                pc_r <= redirect_pc_i;
            end else if (load_s) begin
                pc_r <= pc_seq_i;
            end else begin
                pc_r <= pc_r;
            end

            case (state_r)
                S_REQ: begin
                    if (imem_gnt_i && redirect_i) begin
                        // Old address was accepted; its response is stale.
                        state_r <= S_DROP;
                    end else if (imem_gnt_i) begin
                        state_r <= S_WAIT;
                    end else begin
                        state_r <= S_REQ;
                    end
                end
                S_WAIT: begin
                    if (redirect_i) begin
                        state_r <= imem_rvalid_i ? S_REQ : S_DROP;
                    end else if (imem_rvalid_i && stall_i) begin
                        hold_buf_r <= imem_rdata_i;
                        state_r    <= S_HOLD;
                    end else if (imem_rvalid_i) begin
                        state_r <= S_REQ;
                    end else begin
                        state_r <= S_WAIT;
                    end
                end
                S_HOLD: begin
                    if (redirect_i) begin
                        hold_buf_r <= DATA_WIDTH'(NOP);
                        state_r    <= S_REQ;
                    end else if (!stall_i) begin
                        state_r <= S_REQ;
                    end else begin
                        state_r <= S_HOLD;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid_i) begin
                        state_r <= S_REQ;
                    end else begin
                        state_r <= S_DROP;
                    end
                end
                default: begin
                    state_r <= S_REQ;
                end
            endcase
        end
    end

    kim_ifid_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ifid (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load_s),
        .clear    (redirect_i),
        .hold     (stall_i),
        .instr_in (load_data_s),
        .pc_in    (pc_r),
        .pc4_in   (pc_seq_i),
        .valid    (ifid_valid_o),
        .instr    (ifid_instr_o),
        .pc       (ifid_pc_o),
        .pc4      (ifid_pc4_o)
    );

    // Request is decoded from the state register and forced low under reset.
    assign imem_req_o  = (state_r == S_REQ) && reset_n;
    assign imem_addr_o = pc_r;
    assign pc_o        = pc_r;

endmodule

// File: tb/tb_kim_if_pc_fetch.sv
// Directed bench for kim_if_pc_fetch; the bench plays the PC adder and imem.
module tb_kim_if_pc_fetch;

    logic        clk;
    logic        reset_n;
    logic [31:0] pc_o;
    logic [31:0] pc_seq_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        stall_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        ifid_valid_o;
    logic [31:0] ifid_instr_o;
    logic [31:0] ifid_pc_o;
    logic [31:0] ifid_pc4_o;

    int n_tests;
    int n_fail;

    kim_if_pc_fetch dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pc_o          (pc_o),
        .pc_seq_i      (pc_seq_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .stall_i       (stall_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .ifid_valid_o  (ifid_valid_o),
        .ifid_instr_o  (ifid_instr_o),
        .ifid_pc_o     (ifid_pc_o),
        .ifid_pc4_o    (ifid_pc4_o)
    );

    // External sequential-PC adder.
    assign pc_seq_i = pc_o + 32'd4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic v, input logic [31:0] ins,
                            input logic [31:0] pc, input logic [31:0] pc4);
        chk({tag, ".valid"}, {31'd0, ifid_valid_o}, {31'd0, v});
        chk({tag, ".instr"}, ifid_instr_o, ins);
        chk({tag, ".pc"},    ifid_pc_o, pc);
        chk({tag, ".pc4"},   ifid_pc4_o, pc4);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = 32'd0;
        stall_i = 1'b0;
        imem_gnt_i = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i = 32'd0;

        // Reset state
        tick();
        tick();
        chk("rst.req", {31'd0, imem_req_o}, 32'd0);
        chk("rst.pc", pc_o, 32'h0000_0000);
        chk_ifid("rst.ifid", 1'b0, 32'd0, 32'd0, 32'd0);
        reset_n = 1'b1;
        #1;
        chk("t1.req", {31'd0, imem_req_o}, 32'd1);
        chk("t1.addr", imem_addr_o, 32'h0000_0000);

        // Basic fetch: gnt immediately, rvalid one cycle later
        imem_gnt_i = 1'b1;
        stall_i = 1'b0;
        tick();
        chk("t1.wait_req", {31'd0, imem_req_o}, 32'd0);
        imem_gnt_i = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i = 32'h2008_0005;
        tick();
        imem_rvalid_i = 1'b0;
        chk_ifid("t1.ifid", 1'b1, 32'h2008_0005, 32'h0, 32'h4);
        chk("t1.next_addr", imem_addr_o, 32'h4);
        chk("t1.next_req", {31'd0, imem_req_o}, 32'd1);

        // Stall while response arrives: skid buffer, no request
        imem_gnt_i = 1'b1;
        stall_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i = 32'hAAAA_0001;
        tick();
        imem_rvalid_i = 1'b0;
        chk("t2.hold_req0", {31'd0, imem_req_o}, 32'd0);
        chk_ifid("t2.hold0", 1'b1, 32'h2008_0005, 32'h0, 32'h4);
        tick();
        tick();
        chk("t2.hold_req2", {31'd0, imem_req_o}, 32'd0);
        chk_ifid("t2.hold2", 1'b1, 32'h2008_0005, 32'h0, 32'h4);
        stall_i = 1'b0;
        tick();
        chk_ifid("t2.unstall", 1'b1, 32'hAAAA_0001, 32'h4, 32'h8);
        chk("t2.next_addr", imem_addr_o, 32'h8);
        chk("t2.next_req", {31'd0, imem_req_o}, 32'd1);

        // Redirect in S_WAIT without rvalid -> drop next response
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0;
        chk("t3.bubble", {31'd0, ifid_valid_o}, 32'd0);
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_0100;
        tick();
        redirect_i = 1'b0;
        chk("t3.drop_req", {31'd0, imem_req_o}, 32'd0);
        chk("t3.drop_pc", pc_o, 32'h100);
        imem_rvalid_i = 1'b1;
        imem_rdata_i = 32'hDEAD_BEEF;
        tick();
        imem_rvalid_i = 1'b0;
        chk("t3.discard_valid", {31'd0, ifid_valid_o}, 32'd0);
        chk("t3.req", {31'd0, imem_req_o}, 32'd1);
        chk("t3.addr", imem_addr_o, 32'h100);

        // Redirect in the same cycle as req & gnt
        imem_gnt_i = 1'b1;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_0200;
        tick();
        imem_gnt_i = 1'b0;
        redirect_i = 1'b0;
        chk("t4.drop_req", {31'd0, imem_req_o}, 32'd0);
        tick();
        chk("t4.drop_req2", {31'd0, imem_req_o}, 32'd0);
        imem_rvalid_i = 1'b1;
        imem_rdata_i = 32'hBAD0_0100;
        tick();
        imem_rvalid_i = 1'b0;
        chk("t4.discard_valid", {31'd0, ifid_valid_o}, 32'd0);
        chk("t4.addr", imem_addr_o, 32'h200);
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i = 32'h1234_5678;
        tick();
        imem_rvalid_i = 1'b0;
        chk_ifid("t4.ifid", 1'b1, 32'h1234_5678, 32'h200, 32'h204);
        chk("t4.next_addr", imem_addr_o, 32'h204);

        // PC wrap through the adder
        redirect_i = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        tick();
        redirect_i = 1'b0;
        chk("t5.kill", {31'd0, ifid_valid_o}, 32'd0);
        chk("t5.req", {31'd0, imem_req_o}, 32'd1);
        chk("t5.addr", imem_addr_o, 32'hFFFF_FFFC);
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i = 32'h0BAD_F00D;
        tick();
        imem_rvalid_i = 1'b0;
        chk_ifid("t5.ifid", 1'b1, 32'h0BAD_F00D, 32'hFFFF_FFFC, 32'h0);
        chk("t5.next_addr", imem_addr_o, 32'h0);

        // Asynchronous reset while in S_HOLD
        imem_gnt_i = 1'b1;
        stall_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i = 32'h1111_2222;
        tick();
        imem_rvalid_i = 1'b0;
        tick();
        chk("t6.hold_req", {31'd0, imem_req_o}, 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6.async_req", {31'd0, imem_req_o}, 32'd0);
        chk("t6.async_pc", pc_o, 32'h0);
        chk_ifid("t6.async", 1'b0, 32'd0, 32'd0, 32'd0);
        tick();
        reset_n = 1'b1;
        #1;
        chk("t6.restart_req", {31'd0, imem_req_o}, 32'd1);
        chk("t6.restart_addr", imem_addr_o, 32'h0);
        stall_i = 1'b0;
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i = 32'h3333_4444;
        tick();
        imem_rvalid_i = 1'b0;
        chk_ifid("t6.refetch", 1'b1, 32'h3333_4444, 32'h0, 32'h4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
